ps2_key_event_decoder: RTL



---
 rtl/ps2_pkg.sv | 52 +++++
 rtl/key_event_fifo.sv | 52 +++++
 rtl/ps2_key_event_decoder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and event layout for the PS/2 key event decoder.
package ps2_pkg;

   localparam logic [7:0] SC_E0     = 8'hE0;
   localparam logic [7:0] SC_F0     = 8'hF0;
   localparam logic [7:0] SC_E1     = 8'hE1;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_NUM    = 8'h77;

   localparam logic [2:0] E1_SKIP = 3'd7;

   localparam int unsigned MOD_SHIFT = 0;
   localparam int unsigned MOD_CTRL  = 1;
   localparam int unsigned MOD_ALT   = 2;
   localparam int unsigned MOD_CAPS  = 3;
   localparam int unsigned MOD_NUM   = 4;
   localparam int unsigned MOD_W     = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GOT_E0,
      ST_GOT_F0,
      ST_GOT_E0F0,
      ST_SKIP_E1
   } state_t;

   typedef struct packed {
      logic       rpt;
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } evt_t;

   localparam int unsigned EVT_W = $bits(evt_t);

   // Controller acks, BAT results and error codes never become key events.
   function automatic logic is_ignored(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_fake_shift(input logic [7:0] b);
      return (b == SC_LSHIFT) || (b == SC_RSHIFT);
   endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead synchronous FIFO; a push while full succeeds only if a pop happens in the same cycle.
module key_event_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = EVT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Turns set-2 scancode bytes into make/break events with modifier tracking,
// repeat detection and a buffered valid/ready output.
module ps2_key_event_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter bit          SUPPRESS_REPEAT = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES  = 50000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   byte_in,
   input  logic         byte_valid,
   input  logic         evt_ready,
   output logic         evt_valid,
   output logic [7:0]   evt_code,
   output logic         evt_ext,
   output logic         evt_break,
   output logic         evt_repeat,
   output logic [MOD_W-1:0] mods,
   output logic [7:0]   key_count,
   output logic         overflow,
   input  logic         clr_ovf
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state, state_nxt;
   logic [2:0]    skip_cnt, skip_nxt;
   logic [TW-1:0] to_cnt;
   logic          dec_fire, dec_ext, dec_brk;

   logic [8:0] last_key;
   logic       last_valid, key_match, is_rpt, new_make, push;
   logic       lshift, rshift, ctrl, alt, caps, num;
   logic       fifo_full, fifo_empty, pop_go;
   evt_t       push_evt, head_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         skip_cnt <= '0;
         to_cnt   <= '0;
      end else begin
         state    <= state_nxt;
         skip_cnt <= skip_nxt;
         if (byte_valid || state == ST_IDLE || to_cnt == TO_LAST) to_cnt <= '0;
         else                                                      to_cnt <= to_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      skip_nxt  = skip_cnt;
      dec_fire  = 1'b0;
      dec_ext   = 1'b0;
      dec_brk   = 1'b0;
      if (byte_valid) begin
         unique case (state)
            ST_IDLE: begin
               if (byte_in == SC_E0)      state_nxt = ST_GOT_E0;
               else if (byte_in == SC_F0) state_nxt = ST_GOT_F0;
               else if (byte_in == SC_E1) begin
                  state_nxt = ST_SKIP_E1;
                  skip_nxt  = E1_SKIP;
               end else if (!is_ignored(byte_in)) dec_fire = 1'b1;
            end
            ST_GOT_E0: begin
               if (byte_in == SC_F0) state_nxt = ST_GOT_E0F0;
               else begin
                  state_nxt = ST_IDLE;
                  dec_fire  = !is_fake_shift(byte_in);
                  dec_ext   = 1'b1;
               end
            end
            ST_GOT_F0: begin
               state_nxt = ST_IDLE;
               dec_fire  = 1'b1;
               dec_brk   = 1'b1;
            end
            ST_GOT_E0F0: begin
               state_nxt = ST_IDLE;
               dec_fire  = !is_fake_shift(byte_in);
               dec_ext   = 1'b1;
               dec_brk   = 1'b1;
            end
            ST_SKIP_E1: begin
               skip_nxt = skip_cnt - 3'd1;
               if (skip_cnt == 3'd1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end else if (state != ST_IDLE && to_cnt == TO_LAST) begin
         state_nxt = ST_IDLE;
      end
   end

   // A make matching the remembered key is a typematic repeat; a matching break re-arms detection.
   assign key_match = last_valid && (last_key == {dec_ext, byte_in});
   assign is_rpt    = dec_fire && !dec_brk && key_match;
   assign new_make  = dec_fire && !dec_brk && !key_match;
   assign push      = dec_fire && !(is_rpt && SUPPRESS_REPEAT);
   assign pop_go    = evt_valid && evt_ready;
   assign push_evt  = '{rpt: is_rpt, brk: dec_brk, ext: dec_ext, code: byte_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_key   <= '0;
         last_valid <= 1'b0;
         key_count  <= '0;
         overflow   <= 1'b0;
         lshift     <= 1'b0;
         rshift     <= 1'b0;
         ctrl       <= 1'b0;
         alt        <= 1'b0;
         caps       <= 1'b0;
         num        <= 1'b0;
      end else begin
         if (new_make) begin
            last_key   <= {dec_ext, byte_in};
            last_valid <= 1'b1;
            key_count  <= key_count + 8'd1;
         end else if (dec_fire && dec_brk && key_match) begin
            last_valid <= 1'b0;
         end
         if (push && fifo_full && !pop_go) overflow <= 1'b1;
         else if (clr_ovf)                 overflow <= 1'b0;
         if (dec_fire) begin
            if (byte_in == SC_LSHIFT) lshift <= !dec_brk;
            if (byte_in == SC_RSHIFT) rshift <= !dec_brk;
            if (byte_in == SC_CTRL)   ctrl   <= !dec_brk;
            if (byte_in == SC_ALT)    alt    <= !dec_brk;
         end
         if (new_make && byte_in == SC_CAPS)             caps <= !caps;
         if (new_make && byte_in == SC_NUM && !dec_ext)  num  <= !num;
      end
   end

   always_comb begin
      mods            = '0;
      mods[MOD_SHIFT] = lshift | rshift;
      mods[MOD_CTRL]  = ctrl;
      mods[MOD_ALT]   = alt;
      mods[MOD_CAPS]  = caps;
      mods[MOD_NUM]   = num;
   end

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_evt),
      .pop   (pop_go),
      .dout  (head_evt),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign evt_valid  = !fifo_empty;
   assign evt_code   = head_evt.code;
   assign evt_ext    = head_evt.ext;
   assign evt_break  = head_evt.brk;
   assign evt_repeat = head_evt.rpt;

endmodule
